// File: rtl/sample_pdff_pkg.sv
// rtl/sample_pdff_pkg.sv - shared limits, defaults and word type for the pdff delay line
package sample_pdff_pkg;

    localparam int DEF_WIDTH  = 1;
    localparam int DEF_STAGES = 1;
    localparam int MAX_WIDTH  = 64;
    localparam int MAX_STAGES = 16;

    typedef logic [MAX_WIDTH-1:0] pdff_word_t;

endpackage

// File: rtl/sample_pdff_stage.sv
// rtl/sample_pdff_stage.sv - one WIDTH-bit register with synchronous reset to RESET_VALUE
module sample_pdff_stage
    import sample_pdff_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/sample_pdff_core.sv
// rtl/sample_pdff_core.sv - parameterised D-register delay line, STAGES deep and WIDTH wide
module sample_pdff_core
    import sample_pdff_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               STAGES      = DEF_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("sample_pdff_core: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (STAGES < 0 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("sample_pdff_core: STAGES %0d outside 0..%0d", STAGES, MAX_STAGES);
    end

    if (STAGES == 0) begin : g_passthru
        // No storage: clk and reset are intentionally ignored.
        logic unused_ctrl;
        assign unused_ctrl = clk ^ reset;
        assign q           = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] chain [STAGES+1];

        assign chain[0] = d;

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            sample_pdff_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .d     (chain[i]),
                .q     (chain[i+1])
            );
        end

        assign q = chain[STAGES];

`ifndef SYNTHESIS
        // Counts consecutive reset-free edges so the delay check only fires once the pipe is clean.
        logic [4:0] clean_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                clean_cnt <= '0;
            end else if (clean_cnt < 5'(STAGES)) begin
                clean_cnt <= clean_cnt + 5'd1;
            end
        end

        a_known_after_reset : assert property (@(posedge clk) reset |=> !$isunknown(q))
            else $error("sample_pdff_core: q unknown after reset");

        a_delay : assert property (@(posedge clk) (clean_cnt >= 5'(STAGES)) |-> (q == $past(d, STAGES)))
            else $error("sample_pdff_core: q does not match d delayed by STAGES");
`endif
    end

endmodule

// File: tb/tb_sample_pdff_core.sv
// tb/tb_sample_pdff_core.sv - scoreboard bench over default, 8x3 and 4x0 delay-line configurations
module tb_sample_pdff_core;

    logic       clk;
    logic       reset;
    logic [0:0] d1, q1;
    logic [7:0] d8, q8;
    logic [3:0] d4, q4;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp1 [$];
    logic [7:0] exp8 [$];
    logic [7:0] exp4 [$];

    logic       hist_rst [$];
    logic       hist_d1  [$];
    logic [7:0] hist_d8  [$];

    sample_pdff_core u_dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (q1)
    );

    sample_pdff_core #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .d     (d8),
        .q     (q8)
    );

    sample_pdff_core #(.WIDTH(4), .STAGES(0)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .d     (d4),
        .q     (q4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // A stage's content is the input sampled s edges back, unless any reset hit it along the way.
    function automatic bit reset_in_window(input int s);
        int n = hist_rst.size();
        for (int k = 0; k < s; k++) begin
            if (n - 1 - k >= 0 && hist_rst[n-1-k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] model1();
        if (reset_in_window(1)) return 8'h00;
        return {7'd0, hist_d1[hist_d1.size()-1]};
    endfunction

    function automatic logic [7:0] model8();
        if (reset_in_window(3)) return 8'hA5;
        return hist_d8[hist_d8.size()-3];
    endfunction

    // Inputs change just after the negedge, glitch briefly, then settle well before the posedge.
    task automatic step(input logic r, input logic v1, input logic [7:0] v8, input logic [3:0] v4);
        @(negedge clk);
        #1;
        reset = r;
        d1    = ~v1;
        d8    = ~v8;
        d4    = v4;
        exp4.push_back({4'd0, v4});
        #2;
        d1 = v1;
        d8 = v8;
        @(posedge clk);
        hist_rst.push_back(r);
        hist_d1.push_back(v1);
        hist_d8.push_back(v8);
        exp1.push_back(model1());
        exp8.push_back(model8());
    endtask

    always @(negedge clk) begin
        if (exp1.size() > 0) chk("q_default", {7'd0, q1}, exp1.pop_front());
        if (exp8.size() > 0) chk("q_w8_s3", q8, exp8.pop_front());
        if (exp4.size() > 0) chk("q_w4_s0", {4'd0, q4}, exp4.pop_front());
    end

    initial begin
        logic [9:0] follow;
        reset = 1'b1;
        d1    = 1'b1;
        d8    = 8'h00;
        d4    = 4'h0;

        step(1'b1, 1'b1, 8'hFF, 4'h9);
        step(1'b1, 1'b1, 8'hFF, 4'h9);

        step(1'b0, 1'b0, 8'h01, 4'h3);
        step(1'b0, 1'b0, 8'h02, 4'hC);
        step(1'b0, 1'b0, 8'h03, 4'h5);
        step(1'b0, 1'b0, 8'h00, 4'hA);
        step(1'b0, 1'b0, 8'h00, 4'h1);

        follow = 10'b1101001101;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, follow[i], 8'(i * 17), 4'(i));
        end

        step(1'b1, 1'b1, 8'h5A, 4'hF);

        for (int i = 0; i < 6; i++) begin
            step(1'b0, i[0] ? 1'b0 : 1'b1, 8'(8'h10 + i), 4'(i + 3));
        end
        step(1'b1, 1'b0, 8'h77, 4'h6);
        step(1'b0, 1'b1, 8'h88, 4'h7);
        step(1'b0, 1'b0, 8'h99, 4'h8);
        step(1'b0, 1'b1, 8'hAA, 4'h2);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom), 4'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        chk("drain_q_default", 8'(exp1.size()), 8'd0);
        chk("drain_q_w8_s3", 8'(exp8.size()), 8'd0);
        chk("drain_q_w4_s0", 8'(exp4.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_pdff_core.md
Name: sample_pdff_core

Overview:
- Parameterized synchronous D-type register pipeline. With default parameters it is a single 1-bit D flip-flop: q takes the value of d at each rising clk edge.
- Used as the sample DUT for the class-based verification flow. A driver and a collector reach it through a virtual interface carrying clk, reset, d and q.
- Optional width and depth parameters let the same block serve as a multi-bit, multi-stage delay line.

Parameters:
- WIDTH, 1, bit width of d and q; legal range 1..64.
- STAGES, 1, number of register stages between d and q; legal range 0..16. 0 means combinational pass-through (q = d) and reset is ignored.
- RESET_VALUE, '0 (WIDTH bits), value loaded into every stage on reset.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- d  input  WIDTH  data input, sampled on each rising clk edge.
- q  output  WIDTH  data output, driven directly from the last stage register (no output logic).

Behaviour:
- Clocking: one clock domain (clk). No gated clocks and no asynchronous paths.
- Reset:
  - Synchronous, active-high.
  - On a rising clk edge with reset=1, every stage loads RESET_VALUE. q = RESET_VALUE from that edge onward.
  - Reset takes priority over d on the same edge.
- Normal operation (reset=0), on each rising edge:
  - stage[0] <= d.
  - stage[i] <= stage[i-1] for i = 1..STAGES-1.
  - q = stage[STAGES-1].
- Latency: exactly STAGES rising edges from d to q. With defaults, q(n+1) = d(n), where n indexes edges.
- Power-up: before the first reset edge, q is unspecified (X in simulation). The bench must apply reset before checking q.
- Reset mid-stream:
  - All in-flight data is discarded. q = RESET_VALUE starting the edge reset is sampled high.
  - After reset deasserts, the first new d value appears on q STAGES edges later.
  - Intermediate outputs in between read RESET_VALUE.
- Back-to-back changes: every cycle's d value is captured independently; no hold or enable behaviour. A d toggling every cycle appears on q toggling every cycle, delayed by STAGES.
- Glitch tolerance: d changes between rising edges have no effect. Only the value at the rising edge is stored.
- STAGES=0: q = d combinationally; reset has no effect.
- Elaboration checks: an out-of-range WIDTH or STAGES causes an elaboration-time $error.
- Assertions (simulation only, disabled in synthesis):
  - q is never X/Z one edge after reset is sampled high.
  - With reset low for STAGES consecutive edges, q equals d delayed by STAGES, i.e. $past(d, STAGES).

Decomposition:
- Package sample_pdff_pkg holds:
  - localparam defaults: DEF_WIDTH=1, DEF_STAGES=1.
  - MAX_WIDTH=64, MAX_STAGES=16.
  - typedef logic [MAX_WIDTH-1:0] pdff_word_t.
- Sub-module sample_pdff_stage: one WIDTH-bit register with synchronous reset to RESET_VALUE.
- Top-level structure:
  - A generate loop chains STAGES instances of sample_pdff_stage.
  - A separate generate branch handles STAGES=0.
  - Parameter checks and assertions live in the top.
- Interface: sample_interface (clk input; reset, d, q signals) remains bench-side only.

Test Plan (clk period 10 ns, defaults unless stated):
- Reset: hold reset=1, d=1 for 2 edges -> q=0 after the first edge; q stays 0 while reset=1.
- Follow: reset=0, drive 10 d values 1,0,1,1,0,0,1,0,1,1, one per edge -> q reproduces each value one edge later, 10/10 match.
- Priority: reset=1 and d=1 sampled on the same edge -> q=0, not 1.
- Mid-stream reset: streaming alternating 1/0, assert reset for one edge -> q=0 on that edge; the next d=1 appears on q one edge after reset deasserts.
- WIDTH=8, STAGES=3, RESET_VALUE=8'hA5:
  - Reset -> q=8'hA5.
  - Then drive 8'h01, 8'h02, 8'h03 -> q=8'h01 on edge 3 after release, 8'h02 on edge 4, 8'h03 on edge 5.
- STAGES=0, WIDTH=4: d=4'h9 -> q=4'h9 in the same delta; reset=1 does not change q.
